lstm_gate_serializer: RTL and testbench
=======================================

Name: lstm_gate_serializer

Overview:
- Sits directly upstream of the LSTM 4-to-1 gate multiplexer.
- Accepts one cell's four gate words in parallel through a valid/ready handshake and holds them stable on the mux data inputs.
- Steps the mux select 0,1,2,3 (gate a, b, c, d) with one word per accepted downstream beat.
- Tracks the cell index within a timestep and flags the last word of the last cell.

Parameters:
- WIDTH, 32: signed gate word width; matches the mux WIDTH.
- N_CELLS, 8: cells per timestep; must be >= 1.
- IDX_W, 3: width of the cell index; 2**IDX_W >= N_CELLS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort; returns to IDLE and zeroes cell index.
- in_valid  input  1  upstream gate set valid.
- in_ready  output  1  block can accept a gate set this cycle.
- in_a  input  WIDTH  signed gate a word.
- in_b  input  WIDTH  signed gate b word.
- in_c  input  WIDTH  signed gate c word.
- in_d  input  WIDTH  signed gate d word.
- o_a  output  WIDTH  registered gate a; drives mux i_a.
- o_b  output  WIDTH  registered gate b; drives mux i_b.
- o_c  output  WIDTH  registered gate c; drives mux i_c.
- o_d  output  WIDTH  registered gate d; drives mux i_d.
- o_sel  output  2  mux select.
- out_valid  output  1  mux output word is valid.
- out_ready  input  1  consumer accepts the current word.
- o_cell_idx  output  IDX_W  index of the cell being issued.
- o_last  output  1  current word is gate d of cell N_CELLS-1.

Behaviour:
- Reset (rst=1, asynchronous): all state clears immediately.
  - State goes to IDLE.
  - o_a..o_d, o_sel, o_cell_idx, out_valid and o_last go to 0.
  - in_ready goes to 1 once rst deasserts.
  - Reset mid-issue discards the held set; no partial words are emitted afterwards.
- FSM has two states, IDLE and ISSUE.
- IDLE:
  - out_valid=0 and in_ready=1.
  - When in_valid=1, in_a..in_d are captured into o_a..o_d, o_sel is set to 0, and the FSM goes to ISSUE.
  - The first word is therefore valid on the cycle after the accept (latency 1).
- ISSUE:
  - out_valid=1.
  - o_a..o_d are held constant; the mux output is a pure function of the held words and o_sel.
  - When out_ready=1 and o_sel<3, o_sel increments by 1.
  - When out_ready=1 and o_sel=3, the cell completes:
    - o_cell_idx increments, wrapping from N_CELLS-1 to 0.
    - If in_valid=1 in the same cycle, the new set is captured, o_sel becomes 0 and the FSM stays in ISSUE. This gives back-to-back cells with no bubble: 4 words per 4 cycles.
    - Otherwise the FSM goes to IDLE.
  - When out_ready=0, o_sel and the held words do not change (stall).
- in_ready = (state==IDLE) OR (state==ISSUE AND o_sel==3 AND out_ready). This is a combinational path from out_ready.
- in_valid while in_ready=0 is ignored; upstream must hold its data until the handshake completes.
- o_last = out_valid AND o_sel==3 AND o_cell_idx==N_CELLS-1 (combinational).
- clr:
  - Takes priority over all handshakes.
  - Next cycle: IDLE, o_sel=0, o_cell_idx=0, out_valid=0.
  - The held words may stay but are don't-care.
  - A set presented with clr=1 is not accepted, even if in_ready=1.
- No arithmetic on data; words pass through bit-exact, sign preserved.
- N_CELLS=1: o_cell_idx stays 0 and o_last is asserted on every gate d.

Test Plan:
- Single set: after reset, in_a=1, in_b=-2, in_c=3, in_d=-4 with in_valid for 1 cycle and out_ready=1 -> on cycles 1..4, o_sel=0,1,2,3, out_valid=1, mux output 1,-2,3,-4; cycle 5 IDLE, in_ready=1.
- Backpressure: out_ready low on cycles 2-3 of issue -> o_sel frozen at 1, o_b held at -2, no word skipped or duplicated; the 4 words still complete in order.
- Back-to-back, N_CELLS=8: sets {10,11,12,13} through {80,81,82,83} with in_valid held high and out_ready=1 -> 32 consecutive valid cycles with no bubble; o_cell_idx 0..7; o_last exactly once, on word 83; o_cell_idx wraps to 0.
- Mid-issue reset: assert rst while o_sel=2 -> same cycle out_valid=0, o_sel=0, o_cell_idx=0, o_a..o_d=0; after release a new set issues from o_sel=0.
- clr with in_valid: clr=1 and in_valid=1 both asserted while in ISSUE at o_sel=3 with out_ready=1 -> next cycle IDLE, o_cell_idx=0, the set is not accepted, out_valid=0.
- Sign extremes, WIDTH=32: in_a=0x80000000, in_d=0x7FFFFFFF -> mux outputs are bit-exact, with no sign change.

Source files
------------

// File: rtl/lstm_gate_serializer.sv
// Holds one cell's four gate words stable for a 4:1 mux and steps the select per accepted beat.
// States: IDLE = waiting for a gate set (in_ready=1) | ISSUE = presenting words, o_sel 0..3
module lstm_gate_serializer #(
  parameter int WIDTH   = 32,
  parameter int N_CELLS = 8,
  parameter int IDX_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  input  logic signed [WIDTH-1:0] in_c,
  input  logic signed [WIDTH-1:0] in_d,
  output logic signed [WIDTH-1:0] o_a,
  output logic signed [WIDTH-1:0] o_b,
  output logic signed [WIDTH-1:0] o_c,
  output logic signed [WIDTH-1:0] o_d,
  output logic [1:0]              o_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        o_cell_idx,
  output logic                    o_last
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

  state_t                  r_state, w_state_nxt;
  logic signed [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic signed [WIDTH-1:0] w_a_nxt, w_b_nxt, w_c_nxt, w_d_nxt;
  logic [1:0]              r_sel, w_sel_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic                    w_cell_done, w_accept;

  assign w_cell_done = (r_state == S_ISSUE) && out_ready && (r_sel == 2'd3);
  assign in_ready    = (r_state == S_IDLE) || w_cell_done;
  // clr blocks the capture even while in_ready is high
  assign w_accept    = in_ready && in_valid && !clr;

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_sel_nxt   = r_sel;
    w_idx_nxt   = r_idx;
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_sel_nxt   = 2'd0;
      w_idx_nxt   = '0;
    end else begin
      if (w_cell_done) begin
        w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        w_state_nxt = S_IDLE;
        w_sel_nxt   = 2'd0;
      end else if (r_state == S_ISSUE && out_ready) begin
        w_sel_nxt = r_sel + 2'd1;
      end
      if (w_accept) begin
        w_a_nxt     = in_a;
        w_b_nxt     = in_b;
        w_c_nxt     = in_c;
        w_d_nxt     = in_d;
        w_sel_nxt   = 2'd0;
        w_state_nxt = S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_sel   <= 2'd0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_sel   <= w_sel_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign o_a        = r_a;
  assign o_b        = r_b;
  assign o_c        = r_c;
  assign o_d        = r_d;
  assign o_sel      = r_sel;
  assign o_cell_idx = r_idx;
  assign out_valid  = (r_state == S_ISSUE);
  assign o_last     = out_valid && (r_sel == 2'd3) && (r_idx == LAST_IDX);

endmodule

// File: tb/tb_lstm_gate_serializer.sv
// Directed bench for lstm_gate_serializer; the downstream 4:1 mux is modelled from o_sel and o_a..o_d.
module tb_lstm_gate_serializer;

  localparam int WIDTH   = 32;
  localparam int N_CELLS = 8;
  localparam int IDX_W   = 3;

  logic                    clk = 1'b0;
  logic                    rst, clr, in_valid, out_ready;
  logic                    in_ready, out_valid, o_last;
  logic signed [WIDTH-1:0] in_a, in_b, in_c, in_d;
  logic signed [WIDTH-1:0] o_a, o_b, o_c, o_d;
  logic [1:0]              o_sel;
  logic [IDX_W-1:0]        o_cell_idx;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid, n_last;

  lstm_gate_serializer #(.WIDTH(WIDTH), .N_CELLS(N_CELLS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_d(o_d),
    .o_sel(o_sel), .out_valid(out_valid), .out_ready(out_ready),
    .o_cell_idx(o_cell_idx), .o_last(o_last)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] mux_out();
    case (o_sel)
      2'd0:    return o_a;
      2'd1:    return o_b;
      2'd2:    return o_c;
      default: return o_d;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [WIDTH-1:0] a, b, c, d);
    in_a = a; in_b = b; in_c = c; in_d = d;
  endtask

  task automatic chk_word(input string tag, input int sel, input logic [WIDTH-1:0] w);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sel"}, 32'(o_sel), 32'(sel));
    chk({tag, "_mux"}, mux_out(), w);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sel", 32'(o_sel), 0);
    chk("rst_idx", 32'(o_cell_idx), 0);
    chk("rst_oa", o_a, 0);
    chk("rst_last", 32'(o_last), 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // single set, latency 1, words in order
    drive(1, -2, 3, -4); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_word("single0", 0, 32'd1);
    chk("single_in_ready_busy", 32'(in_ready), 0);
    tick(); chk_word("single1", 1, -32'sd2);
    tick(); chk_word("single2", 2, 32'd3);
    tick(); chk_word("single3", 3, -32'sd4);
    chk("single3_last", 32'(o_last), 0);
    chk("single3_in_ready", 32'(in_ready), 1);
    tick();
    chk("single_idle_valid", 32'(out_valid), 0);
    chk("single_idle_ready", 32'(in_ready), 1);
    chk("single_idx", 32'(o_cell_idx), 1);

    // backpressure: stall two cycles at o_sel=1
    drive(5, -2, 7, -8); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_word("bp0", 0, 32'd5);
    tick(); chk_word("bp1", 1, -32'sd2);
    out_ready = 1'b0;
    tick(); chk_word("bp_stall_a", 1, -32'sd2);
    chk("bp_stall_ob", o_b, -32'sd2);
    tick(); chk_word("bp_stall_b", 1, -32'sd2);
    out_ready = 1'b1;
    tick(); chk_word("bp2", 2, 32'd7);
    tick(); chk_word("bp3", 3, -32'sd8);
    tick();
    chk("bp_idle", 32'(out_valid), 0);
    chk("bp_idx", 32'(o_cell_idx), 2);

    // back-to-back cells from index 0
    rst = 1'b1; #1; rst = 1'b0;
    tick();
    n_valid = 0; n_last = 0;
    drive(10, 11, 12, 13); in_valid = 1'b1;
    tick();
    for (int c = 0; c < N_CELLS; c++) begin
      for (int w = 0; w < 4; w++) begin
        if (w == 0) begin
          if (c < N_CELLS - 1) drive(10*(c+2), 10*(c+2)+1, 10*(c+2)+2, 10*(c+2)+3);
          else in_valid = 1'b0;
          #1;
        end
        chk_word($sformatf("b2b_c%0d_w%0d", c, w), w, 32'(10*(c+1) + w));
        chk($sformatf("b2b_idx_c%0d_w%0d", c, w), 32'(o_cell_idx), 32'(c));
        chk($sformatf("b2b_last_c%0d_w%0d", c, w), 32'(o_last), 32'((c == N_CELLS-1 && w == 3) ? 1 : 0));
        chk($sformatf("b2b_rdy_c%0d_w%0d", c, w), 32'(in_ready), 32'((w == 3) ? 1 : 0));
        if (out_valid) n_valid++;
        if (o_last) n_last++;
        tick();
      end
    end
    chk("b2b_valid_count", 32'(n_valid), 32);
    chk("b2b_last_count", 32'(n_last), 1);
    chk("b2b_end_valid", 32'(out_valid), 0);
    chk("b2b_wrap_idx", 32'(o_cell_idx), 0);

    // mid-issue async reset at o_sel=2 of the second cell
    drive(100, 101, 102, 103); in_valid = 1'b1;
    tick();
    tick(); tick(); tick(); tick();
    tick(); tick();
    chk_word("mid_pre", 2, 32'd102);
    chk("mid_pre_idx", 32'(o_cell_idx), 1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_sel", 32'(o_sel), 0);
    chk("mid_idx", 32'(o_cell_idx), 0);
    chk("mid_oa", o_a, 0);
    chk("mid_od", o_d, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_no_partial", 32'(out_valid), 0);
    chk("mid_ready", 32'(in_ready), 1);
    drive(200, 201, 202, 203); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_word("mid_new0", 0, 32'd200);
    tick(); chk_word("mid_new1", 1, 32'd201);
    tick(); tick(); tick();
    chk("mid_new_idx", 32'(o_cell_idx), 1);

    // clr with in_valid at o_sel=3 and out_ready=1
    drive(1, 2, 3, 4); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk_word("clr_pre", 3, 32'd4);
    drive(9, 9, 9, 9); in_valid = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_idx", 32'(o_cell_idx), 0);
    chk("clr_sel", 32'(o_sel), 0);
    chk("clr_ready", 32'(in_ready), 1);
    tick();
    chk("clr_not_accepted", 32'(out_valid), 0);

    // sign extremes pass through bit-exact
    drive(32'sh80000000, 0, -1, 32'sh7FFFFFFF); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_word("sign_a", 0, 32'h80000000);
    tick(); chk_word("sign_b", 1, 32'h00000000);
    tick(); chk_word("sign_c", 2, 32'hFFFFFFFF);
    tick(); chk_word("sign_d", 3, 32'h7FFFFFFF);
    tick();
    chk("sign_idle", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
